// File: rtl/clken_pkg.sv
// Shared defaults, divisor type and 50 MHz board divisor constants for the
// clock-enable scheduler.
package clken_pkg;

    localparam int CNT_W_DEFAULT    = 24;
    localparam int CHANNELS_DEFAULT = 4;

    typedef logic [CNT_W_DEFAULT-1:0] clken_div_t;

    // Divisors from the 50 MHz system clock.
    localparam clken_div_t DIV_CPU6 = clken_div_t'(8);          // ~6.25 MHz
    localparam clken_div_t DIV_CPU8 = clken_div_t'(6);          // ~8.33 MHz
    localparam clken_div_t DIV_PS2  = clken_div_t'(5_000);      // 10 kHz
    localparam clken_div_t DIV_LED  = clken_div_t'(25_000_000); // 1 Hz phase

    // Channel-select width, never below one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clken_chan.sv
// One scheduler channel: period counter plus shadow divisor that is only
// swapped in at terminal count, so periods are never shortened or stretched.
module clken_chan
    import clken_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             phase_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic             terminal;

    assign terminal = (div_q != '0) && (cnt_q == div_q - CNT_W'(1));

    // NOTE: every next-state signal is defaulted to its register first, so
    // no path through this block can infer a latch.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        phase_d   = phase_q;

        if (adv_i && div_q != '0) begin
            if (terminal) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                phase_d = ~phase_q;
                if (pending_q) begin
                    div_d     = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A write is only ever accepted with pending_q low, so it cannot
        // collide with the shadow swap above.
        if (wr_i) begin
            if (div_q == '0) begin
                div_d = wr_div_i;
                cnt_d = '0;
            end else begin
                shadow_d  = wr_div_i;
                pending_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
        end
    end

    assign tick_o    = tick_q;
    assign phase_o   = phase_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/clken_sched.sv
// Multi-channel clock-enable scheduler with valid/ready divisor config port.
// Optional single-step input is built when CLKEN_STEP_EN is defined.
module clken_sched
    import clken_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         run_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [sel_w(CHANNELS)-1:0]   cfg_sel_i,
    input  logic [CNT_W-1:0]             cfg_div_i,
`ifdef CLKEN_STEP_EN
    input  logic                         step_i,
`endif
    output logic [CHANNELS-1:0]          tick_o,
    output logic [CHANNELS-1:0]          phase_o,
    output logic [CHANNELS-1:0]          pending_o
);

    localparam int SEL_W = sel_w(CHANNELS);

    logic                  adv;
    logic                  wr_accept;
    logic [CHANNELS-1:0]   pend;
    logic [(1<<SEL_W)-1:0] pend_ext;

`ifdef CLKEN_STEP_EN
    assign adv = run_i | step_i;
`else
    assign adv = run_i;
`endif

    // Unpopulated select codes read as not pending, so they accept and drop.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pend;
    end

    assign cfg_ready_o = ~pend_ext[cfg_sel_i];
    assign wr_accept   = cfg_valid_i & cfg_ready_o;
    assign pending_o   = pend;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clken_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .adv_i     (adv),
            .wr_i      (wr_accept && (cfg_sel_i == SEL_W'(c))),
            .wr_div_i  (cfg_div_i),
            .tick_o    (tick_o[c]),
            .phase_o   (phase_o[c]),
            .pending_o (pend[c])
        );
    end

endmodule

// File: tb/tb_clken_sched.sv
// Self-checking bench for clken_sched: directed scenarios with hand-derived
// expectations plus randomized traffic against a remaining-cycles model.
module tb_clken_sched;

    localparam int CH    = 4;
    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_sel = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             step = 1'b0;
    logic [CH-1:0]    tick, phase, pending;

    int checks = 0;
    int fails  = 0;

    // Model: cycles remaining until the next tick, counted down per advance.
    int               m_rem    [CH];
    logic [CNT_W-1:0] m_div    [CH];
    logic [CNT_W-1:0] m_shadow [CH];
    logic [CH-1:0]    m_pend, m_phase, m_tick;

    always #5 clk = ~clk;

    clken_sched #(.CHANNELS(CH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_sel_i   (cfg_sel),
        .cfg_div_i   (cfg_div),
`ifdef CLKEN_STEP_EN
        .step_i      (step),
`endif
        .tick_o      (tick),
        .phase_o     (phase),
        .pending_o   (pending)
    );

    task automatic model_edge(input bit r, input bit adv, input bit acc,
                              input int sel, input logic [CNT_W-1:0] wdiv);
        if (r) begin
            for (int c = 0; c < CH; c++) begin
                m_rem[c] = 0; m_div[c] = '0; m_shadow[c] = '0;
            end
            m_pend = '0; m_phase = '0; m_tick = '0;
            return;
        end
        m_tick = '0;
        for (int c = 0; c < CH; c++) begin
            if (adv && m_div[c] != 0) begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_tick[c]  = 1'b1;
                    m_phase[c] = ~m_phase[c];
                    if (m_pend[c]) begin
                        m_div[c]  = m_shadow[c];
                        m_pend[c] = 1'b0;
                    end
                    m_rem[c] = int'(m_div[c]);
                end
            end
        end
        if (acc && sel < CH) begin
            if (m_div[sel] == 0) begin
                m_div[sel] = wdiv;
                m_rem[sel] = int'(wdiv);
            end else begin
                m_shadow[sel] = wdiv;
                m_pend[sel]   = 1'b1;
            end
        end
    endtask

    // Advance one clock; the model sees the same inputs the DUT sampled.
    task automatic clk_edge();
        bit adv, acc;
        @(posedge clk);
        adv = run;
`ifdef CLKEN_STEP_EN
        adv = adv | step;
`endif
        acc = cfg_valid && (int'(cfg_sel) >= CH || !m_pend[cfg_sel]);
        model_edge(rst, adv, acc, int'(cfg_sel), cfg_div);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; step = 1'b0;
        clk_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cfg_sel = 2'd1;
        do_reset();
        checks++;
        if ({tick, phase, pending} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got tick/phase/pend %b/%b/%b, want 0/0/0",
                     tick, phase, pending);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b, want 1", cfg_ready);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        run = 1'b1;
        for (int k = 0; k < 100; k++) begin
            clk_edge();
            cfg_sel = 2'(k);
            #1;
            checks++;
            if ({tick, phase, pending} !== '0 || cfg_ready !== 1'b1) begin
                fails++;
                if (bad++ < 5)
                    $display("FAIL idle cyc %0d: tick/phase/pend/ready %b/%b/%b/%b, want 0/0/0/1",
                             k, tick, phase, pending, cfg_ready);
            end
        end
    endtask

    task automatic test_div4();
        do_reset();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = CNT_W'(4); run = 1'b1;
        clk_edge();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            clk_edge();
            checks++;
            if (tick[0] !== (k % 4 == 0) || phase[0] !== ((k / 4) % 2 == 1)) begin
                fails++;
                $display("FAIL div4 k=%0d: tick0/phase0 %b/%b, want %b/%b",
                         k, tick[0], phase[0], (k % 4 == 0), ((k / 4) % 2 == 1));
            end
        end
    endtask

    task automatic test_shadow();
        do_reset();
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = CNT_W'(5); run = 1'b1;
        clk_edge();
        cfg_valid = 1'b0;
        clk_edge();
        cfg_valid = 1'b1; cfg_div = CNT_W'(3);
        clk_edge();
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (pending[1] !== 1'b1 || cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL shadow_pending: pend1/ready %b/%b, want 1/0", pending[1], cfg_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) clk_edge();
            else begin @(posedge clk); model_edge(1'b0, 1'b1, 1'b0, 0, '0); #1; end
            checks++;
            if (tick[1] !== (k == 3 || k == 6 || k == 9) || pending[1] !== (k < 3)) begin
                fails++;
                $display("FAIL shadow k=%0d: tick1/pend1 %b/%b, want %b/%b",
                         k, tick[1], pending[1], (k == 3 || k == 6 || k == 9), (k < 3));
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = CNT_W'(2); run = 1'b1;
        clk_edge();
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = '0;
            end else begin
                cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = '0;
                #1;
                checks++;
                if (cfg_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL disable_ready k=%0d: got %b, want 1", k, cfg_ready);
                end
            end
            clk_edge();
            checks++;
            if (tick[2] !== (k == 2 || k == 4) || phase[2] !== (k >= 2 && k < 4) ||
                pending[2] !== (k == 3) || tick[3] !== 1'b0) begin
                fails++;
                $display("FAIL disable k=%0d: tick/phase/pend %b/%b/%b, want ch2 %b/%b/%b",
                         k, tick, phase, pending, (k == 2 || k == 4), (k >= 2 && k < 4), (k == 3));
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = CNT_W'(4); run = 1'b1;
        clk_edge();
        cfg_valid = 1'b0;
        repeat (6) clk_edge();
        run = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            clk_edge();
            checks++;
            if (tick !== '0 || phase[0] !== 1'b1) begin
                fails++;
                $display("FAIL pause k=%0d: tick/phase0 %b/%b, want 0000/1", k, tick, phase[0]);
            end
        end
        run = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            clk_edge();
            checks++;
            if (tick[0] !== (r == 2 || r == 6)) begin
                fails++;
                $display("FAIL resume r=%0d: tick0 %b, want %b", r, tick[0], (r == 2 || r == 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = CNT_W'(7);
        clk_edge();
        cfg_valid = 1'b0;
        checks++;
        if (pending[0] !== 1'b1) begin
            fails++;
            $display("FAIL resetmid_pend: got %b, want 1", pending[0]);
        end
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        #1;
        checks++;
        if ({tick, phase, pending} !== '0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL resetmid: tick/phase/pend/ready %b/%b/%b/%b, want 0/0/0/1",
                     tick, phase, pending, cfg_ready);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        bit exp_ready;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            run       = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_sel   = 2'($urandom_range(0, CH - 1));
            cfg_div   = CNT_W'($urandom_range(0, 6));
`ifdef CLKEN_STEP_EN
            step      = ($urandom_range(0, 1) == 1);
`endif
            #1;
            exp_ready = !m_pend[cfg_sel];
            checks++;
            if (cfg_ready !== exp_ready) begin
                fails++;
                if (bad++ < 8)
                    $display("FAIL rand_ready k=%0d sel=%0d: got %b, want %b",
                             k, cfg_sel, cfg_ready, exp_ready);
            end
            clk_edge();
            checks++;
            if ({tick, phase, pending} !== {m_tick, m_phase, m_pend}) begin
                fails++;
                if (bad++ < 8)
                    $display("FAIL rand k=%0d: tick/phase/pend %b/%b/%b, want %b/%b/%b",
                             k, tick, phase, pending, m_tick, m_phase, m_pend);
            end
        end
        rst = 1'b0; step = 1'b0; cfg_valid = 1'b0;
    endtask

`ifdef CLKEN_STEP_EN
    task automatic test_step();
        do_reset();
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = CNT_W'(3);
        clk_edge();
        cfg_valid = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            step = 1'b1;
            clk_edge();
            step = 1'b0;
            checks++;
            if (tick[0] !== (p == 3)) begin
                fails++;
                $display("FAIL step p=%0d: tick0 %b, want %b", p, tick[0], (p == 3));
            end
            repeat (2) begin
                clk_edge();
                checks++;
                if (tick[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL step_gap p=%0d: tick0 %b, want 0", p, tick[0]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_div4();
        test_shadow();
        test_disable();
        test_pause();
        test_reset_mid();
`ifdef CLKEN_STEP_EN
        test_step();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
